hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_md_timer.sv | 41 ++++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared pipeline definitions: forwarding-select encodings, mult/div latency
// defaults and the mult/div counter width.
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

   // forwarding select: where an operand comes from
   localparam logic [1:0] FWD_RF  = 2'd0;   // register file (no forward)
   localparam logic [1:0] FWD_MEM = 2'd1;   // result sitting in MEM
   localparam logic [1:0] FWD_WB  = 2'd2;   // result sitting in WB

   // mult/div busy-cycle defaults
   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;

   // counter width; must hold the largest of the two latencies
   localparam int MD_CNT_W = 4;

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// ---------------------------------------------------------------------------
// md_timer
// Occupancy counter for the multi-cycle mult/div unit. A start while idle
// loads the op latency; the count then runs down to zero, one per cycle.
//   clk    in  1  pipeline clock
//   rst_n  in  1  async active-low reset; aborts any running op
//   start  in  1  op starts this cycle (ignored while busy)
//   div    in  1  1 = divide latency, 0 = multiply latency
//   busy   out 1  unit occupied (count != 0)
// ---------------------------------------------------------------------------
module md_timer
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic div,
   output logic busy
);

   localparam logic [MD_CNT_W-1:0] L_MULT = MD_CNT_W'(MULT_CYC);
   localparam logic [MD_CNT_W-1:0] L_DIV  = MD_CNT_W'(DIV_CYC);

   logic [MD_CNT_W-1:0] r_md_cnt;

   // a start while busy is dropped: the running op has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_md_cnt <= '0;
      else if (r_md_cnt != '0)
         r_md_cnt <= r_md_cnt - 1'b1;
      else if (start)
         r_md_cnt <= div ? L_DIV : L_MULT;
   end

   assign busy = (r_md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard unit: load-use / Tuse-Tnew stall detection, D- and E-stage
// forwarding selects, mult/div structural stall and a saturating stall-cycle
// counter.
//   clk, rst_n                 clock, async active-low reset
//   rs_D, rt_D, Tuse_rs/rt_D   D-stage sources and their use times
//   rs_E, rt_E                 E-stage sources
//   A3_E/M/W, RegWrite_E/M/W   destination + write enable per stage
//   Tnew_E, Tnew_M             cycles until that stage's result is ready
//   md_start_E, md_div_E       mult/div launch in E and its kind
//   md_D                       D-stage instruction needs mult/div or HI/LO
//   stall_F, stall_D, flush_E  freeze PC, IF/ID; bubble into ID/EX
//   fwd_rs/rt_D, fwd_rs/rt_E   forwarding selects (FWD_RF/MEM/WB)
//   md_busy                    mult/div unit occupied
//   stall_cnt                  saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  Tuse_rs_D,
   input  logic [1:0]  Tuse_rt_D,
   input  logic [4:0]  rs_E,
   input  logic [4:0]  rt_E,
   input  logic [4:0]  A3_E,
   input  logic [4:0]  A3_M,
   input  logic [4:0]  A3_W,
   input  logic        RegWrite_E,
   input  logic        RegWrite_M,
   input  logic        RegWrite_W,
   input  logic [1:0]  Tnew_E,
   input  logic [1:0]  Tnew_M,
   input  logic        md_start_E,
   input  logic        md_div_E,
   input  logic        md_D,
   output logic        stall_F,
   output logic        stall_D,
   output logic        flush_E,
   output logic [1:0]  fwd_rs_D,
   output logic [1:0]  fwd_rt_D,
   output logic [1:0]  fwd_rs_E,
   output logic [1:0]  fwd_rt_E,
   output logic        md_busy,
   output logic [31:0] stall_cnt
);

   // $0 is hard-wired zero, so it never carries a dependency
   function automatic logic dep(input logic [4:0] r, input logic [4:0] a3,
                                input logic we);
      return (r != 5'd0) && we && (a3 == r);
   endfunction

   // M wins over W; M only forwards once its result is ready (Tnew_M == 0)
   function automatic logic [1:0] fwd_sel(input logic [4:0] r);
      if (dep(r, A3_M, RegWrite_M) && (Tnew_M == 2'd0))
         return FWD_MEM;
      else if (dep(r, A3_W, RegWrite_W))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   logic w_stall_rs, w_stall_rt, w_data_stall, w_md_stall, w_stall;

   // stall when the producer's result arrives later than the consumer needs it
   assign w_stall_rs = (dep(rs_D, A3_E, RegWrite_E) && (Tnew_E > Tuse_rs_D)) ||
                       (dep(rs_D, A3_M, RegWrite_M) && (Tnew_M > Tuse_rs_D));
   assign w_stall_rt = (dep(rt_D, A3_E, RegWrite_E) && (Tnew_E > Tuse_rt_D)) ||
                       (dep(rt_D, A3_M, RegWrite_M) && (Tnew_M > Tuse_rt_D));
   assign w_data_stall = w_stall_rs | w_stall_rt;

   // an op launching in E counts as busy already for the D-stage consumer
   assign w_md_stall = md_D & (md_busy | md_start_E);
   assign w_stall    = w_data_stall | w_md_stall;

   assign stall_F = w_stall;
   assign stall_D = w_stall;
   assign flush_E = w_stall;

   assign fwd_rs_D = fwd_sel(rs_D);
   assign fwd_rt_D = fwd_sel(rt_D);
   assign fwd_rs_E = fwd_sel(rs_E);
   assign fwd_rt_E = fwd_sel(rt_E);

   md_timer #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (md_start_E),
      .div   (md_div_E),
      .busy  (md_busy)
   );

   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (stall_D && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;

endmodule
